// File: rtl/screen_console_ctrl_pkg.sv
// Shared screen geometry, character codes and controller state encodings.
// The VGA lookup path imports this package too, so the row pitch has one source.
package screen_console_ctrl_pkg;

  localparam int DEF_H_SLOTS  = 80;
  localparam int DEF_V_SLOTS  = 60;
  localparam int DEF_ADDR_W   = 13;
  localparam int SCREEN_CELLS = DEF_H_SLOTS * DEF_V_SLOTS;

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_FF    = 8'h0C;

  localparam logic [1:0] ST_CLEAR_ALL       = 2'd0;
  localparam logic [1:0] ST_IDLE            = 2'd1;
  localparam logic [1:0] ST_CHAR_THEN_CLEAR = 2'd2;
  localparam logic [1:0] ST_CLEAR_LINE      = 2'd3;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/screen_clear_seq.sv
// Fill sequencer: walks base..base+length-1, one cell per cycle.
// A start pulse issues the first cell in the same cycle it is asserted.
module screen_clear_seq #(
  parameter int AW = 13,
  parameter int LW = 14
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  input  logic          active_i,
  input  logic [AW-1:0] base_i,
  input  logic [LW-1:0] length_i,
  output logic [AW-1:0] addr_o,
  output logic          wen_o,
  output logic          done_o
);

  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] eff;

  always_comb begin
    eff    = start_i ? '0 : cnt_q;
    wen_o  = (start_i || active_i) && (eff < length_i);
    done_o = active_i && !start_i && (cnt_q >= length_i);
    addr_o = base_i + eff[AW-1:0];
    cnt_d  = wen_o ? (eff + 1'b1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/screen_console_ctrl.sv
// Text-console write controller: byte stream in, character cells out to the
// screen BRAM write port, with cursor tracking and line/screen clears.
//
// state              | meaning
// CLEAR_ALL          | filling every cell with space (after reset or FF)
// IDLE               | accepting bytes, one per cycle
// CHAR_THEN_CLEAR    | last-column character written, line clear next
// CLEAR_LINE         | filling the cursor row with space
module screen_console_ctrl
  import screen_console_ctrl_pkg::*;
#(
  parameter int HORIZONTAL_SLOT_COUNT = DEF_H_SLOTS,
  parameter int VERTICAL_SLOT_COUNT   = DEF_V_SLOTS,
  parameter int SCREEN_ADDRESS_WIDTH  = DEF_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            char_valid,
  input  logic [7:0]                      char_data,
  output logic                            char_ready,
  output logic [SCREEN_ADDRESS_WIDTH-1:0] screen_waddr,
  output logic [6:0]                      screen_wdata,
  output logic                            screen_wen,
  output logic [6:0]                      cursor_x,
  output logic [5:0]                      cursor_y,
  output logic                            busy
);

  localparam int AW = SCREEN_ADDRESS_WIDTH;
  localparam int LW = SCREEN_ADDRESS_WIDTH + 1;
  localparam logic [6:0]    X_LAST    = 7'(HORIZONTAL_SLOT_COUNT - 1);
  localparam logic [5:0]    Y_LAST    = 6'(VERTICAL_SLOT_COUNT - 1);
  localparam logic [AW-1:0] ROW_PITCH = AW'(HORIZONTAL_SLOT_COUNT);
  localparam logic [LW-1:0] LEN_LINE  = LW'(HORIZONTAL_SLOT_COUNT);
  localparam logic [LW-1:0] LEN_ALL   = LW'(HORIZONTAL_SLOT_COUNT * VERTICAL_SLOT_COUNT);

  logic [1:0]    state_q, state_d;
  logic [6:0]    x_q, x_d;
  logic [5:0]    y_q, y_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [6:0]    wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic [5:0]    next_y;
  logic [AW-1:0] next_row_base;
  logic [AW-1:0] cur_addr;

  logic          seq_start, seq_active, seq_full;
  logic [AW-1:0] seq_base;
  logic [LW-1:0] seq_len;
  logic [AW-1:0] seq_addr;
  logic          seq_wen, seq_done;

  assign accept        = (state_q == ST_IDLE) && char_valid;
  assign next_y        = (y_q == Y_LAST) ? '0 : (y_q + 1'b1);
  assign next_row_base = (y_q == Y_LAST) ? '0 : (row_base_q + ROW_PITCH);
  assign cur_addr      = row_base_q + AW'(x_q);

  // Sequencer controls come from registers and inputs only, so they never
  // loop back through the next-state logic that consumes seq_done.
  assign seq_start  = (state_q == ST_CHAR_THEN_CLEAR) ||
                      (accept && ((char_data == CHR_LF) || (char_data == CHR_FF)));
  assign seq_active = (state_q == ST_CLEAR_LINE) || (state_q == ST_CLEAR_ALL);
  assign seq_full   = (state_q == ST_CLEAR_ALL) || (accept && (char_data == CHR_FF));
  assign seq_len    = seq_full ? LEN_ALL : LEN_LINE;
  assign seq_base   = seq_full ? '0 :
                      ((state_q == ST_IDLE) ? next_row_base : row_base_q);

  screen_clear_seq #(
    .AW(AW),
    .LW(LW)
  ) u_clear_seq (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (seq_start),
    .active_i (seq_active),
    .base_i   (seq_base),
    .length_i (seq_len),
    .addr_o   (seq_addr),
    .wen_o    (seq_wen),
    .done_o   (seq_done)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(char_data)) begin
            wen_d   = 1'b1;
            waddr_d = cur_addr;
            wdata_d = char_data[6:0];
            if (x_q == X_LAST) begin
              x_d        = '0;
              y_d        = next_y;
              row_base_d = next_row_base;
              state_d    = ST_CHAR_THEN_CLEAR;
            end else begin
              x_d = x_q + 1'b1;
            end
          end else begin
            case (char_data)
              CHR_CR: x_d = '0;
              CHR_LF: begin
                x_d        = '0;
                y_d        = next_y;
                row_base_d = next_row_base;
                state_d    = ST_CLEAR_LINE;
              end
              CHR_BS: begin
                if (x_q != '0) begin
                  wen_d   = 1'b1;
                  waddr_d = cur_addr - 1'b1;
                  wdata_d = CHR_SPACE[6:0];
                  x_d     = x_q - 1'b1;
                end
              end
              CHR_FF: begin
                x_d        = '0;
                y_d        = '0;
                row_base_d = '0;
                state_d    = ST_CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CHAR_THEN_CLEAR: state_d = ST_CLEAR_LINE;
      ST_CLEAR_LINE, ST_CLEAR_ALL: begin
        if (seq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR_ALL;
    endcase

    if (seq_wen) begin
      wen_d   = 1'b1;
      waddr_d = seq_addr;
      wdata_d = CHR_SPACE[6:0];
    end
  end

  assign ready_d = (state_d == ST_IDLE);
  assign busy_d  = (state_d == ST_CLEAR_ALL) || (state_d == ST_CLEAR_LINE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_CLEAR_ALL;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign char_ready   = ready_q;
  assign screen_wen   = wen_q;
  assign screen_waddr = waddr_q;
  assign screen_wdata = wdata_q;
  assign cursor_x     = x_q;
  assign cursor_y     = y_q;
  assign busy         = busy_q;

endmodule
